mdu_hilo: RTL and testbench



---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_div_step.sv | 32 +++
 rtl/mdu_hilo.sv | 178 +++++++++++++++++
 tb/tb_mdu_hilo.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared encodings and constants for the HI/LO multiply/divide
//               unit (operation codes, sequencer states, iteration count).
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // Operation select, as presented on the op port
    localparam logic [1:0] MDU_MULT  = 2'd0;
    localparam logic [1:0] MDU_MULTU = 2'd1;
    localparam logic [1:0] MDU_DIV   = 2'd2;
    localparam logic [1:0] MDU_DIVU  = 2'd3;

    // Number of shift/add or shift/subtract steps for a full-width operation
    localparam int MDU_ITER = 32;

    // LO value reported for a divide by zero
    localparam logic [31:0] MDU_DIV_ZERO_LO = 32'hFFFF_FFFF;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } mdu_state_t;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_div_step.sv
`default_nettype none
// ============================================================================
// Module      : mdu_div_step
// Description : One combinational restoring-division step. Shifts the next
//               dividend bit into the partial remainder, trial-subtracts the
//               divisor and keeps the difference when it does not underflow.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // The partial remainder is always below the divisor, so the shifted value
    // fits in WIDTH+1 bits and the difference sign bit is the borrow.
    always_comb begin
        w_shift = {i_rem, i_bit};
        w_diff  = w_shift - {1'b0, i_divisor};
        o_q_bit = ~w_diff[WIDTH];
        o_rem   = o_q_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    end

endmodule : mdu_div_step
`default_nettype wire

// File: rtl/mdu_hilo.sv
`default_nettype none
// ============================================================================
// Module      : mdu_hilo
// Description : Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
//               Magnitude datapath runs WIDTH steps, then a fix-up cycle
//               applies signs and writes HI/LO. Busy/done for hazard stalls.
//               Build option MDU_DIV_EN: include the divide datapath; when
//               undefined, divide starts just pulse done/div_zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int               c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    mdu_state_t         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2*WIDTH-1:0] r_acc;     // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   r_b;       // |multiplicand| or |divisor|
    logic               r_neg_q;   // product / quotient must be negated
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_div_zero;

    logic               w_signed;
    logic               w_is_div;
    logic               w_div_bypass;
    logic               w_rs_neg;
    logic               w_rt_neg;
    logic [WIDTH-1:0]   w_rs_mag;
    logic [WIDTH-1:0]   w_rt_mag;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod;

`ifdef MDU_DIV_EN
    localparam logic [WIDTH-1:0] c_DZ_LO = WIDTH'(MDU_DIV_ZERO_LO);

    logic               r_is_div;
    logic               r_neg_r;   // remainder takes the dividend sign
    logic               r_dz;      // divisor was zero
    logic [WIDTH-1:0]   w_rem_next;
    logic               w_q_bit;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    mdu_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
        .i_bit     (r_acc[WIDTH-1]),
        .i_divisor (r_b),
        .o_rem     (w_rem_next),
        .o_q_bit   (w_q_bit)
    );

    // Sign fix for divide results. With a zero divisor the restoring steps
    // leave |rs| in the remainder, so re-applying the dividend sign yields rs.
    always_comb begin
        w_quo_fix = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem_fix = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end

    assign w_div_bypass = 1'b0;
`else
    // Without a divider, divide starts complete immediately
    assign w_div_bypass = w_is_div;
`endif

    // Operand decode, magnitudes, one shift-add step and product sign fix
    always_comb begin
        w_signed = ~op[0];
        w_is_div = op[1];
        w_rs_neg = w_signed & rs_data[WIDTH-1];
        w_rt_neg = w_signed & rt_data[WIDTH-1];
        w_rs_mag = w_rs_neg ? -rs_data : rs_data;
        w_rt_mag = w_rt_neg ? -rt_data : rt_data;
        w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : {WIDTH{1'b0}})};
        w_prod   = r_neg_q ? -r_acc : r_acc;
    end

    // Sequencer, iteration datapath and HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_b        <= '0;
            r_neg_q    <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
`ifdef MDU_DIV_EN
            r_is_div   <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done     <= 1'b0;
                    r_div_zero <= 1'b0;
                    if (start && w_div_bypass) begin
                        r_done     <= 1'b1;
                        r_div_zero <= 1'b1;
                    end else if (start) begin
                        r_acc   <= {{WIDTH{1'b0}}, w_rs_mag};
                        r_b     <= w_rt_mag;
                        r_neg_q <= w_rs_neg ^ w_rt_neg;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
`ifdef MDU_DIV_EN
                        r_is_div <= w_is_div;
                        r_neg_r  <= w_rs_neg;
                        r_dz     <= w_is_div & (rt_data == '0);
`endif
                    end else begin
                        if (mthi) r_hi <= rs_data;
                        if (mtlo) r_lo <= rs_data;
                    end
                end
                S_RUN: begin
`ifdef MDU_DIV_EN
                    if (r_is_div)
                        r_acc <= {w_rem_next, r_acc[WIDTH-2:0], w_q_bit};
                    else
`endif
                        r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
`ifdef MDU_DIV_EN
                    r_div_zero <= r_dz;
                    if (r_is_div) begin
                        r_lo <= r_dz ? c_DZ_LO : w_quo_fix;
                        r_hi <= w_rem_fix;
                    end else
`endif
                    begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule : mdu_hilo
`default_nettype wire

// File: tb/tb_mdu_hilo.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_hilo
// Description : Self-checking bench for mdu_hilo: directed corner operations,
//               hazards (start/mthi while busy, reset mid-operation) and
//               random operations against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_hilo;
    import mdu_pkg::*;

`ifdef MDU_DIV_EN
    localparam bit c_DIV_EN = 1'b1;
`else
    localparam bit c_DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    mdu_hilo #(
        .WIDTH (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: architectural result from plain integer arithmetic
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] e_hi, output logic [31:0] e_lo,
                         output logic e_dz, output int e_lat);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        e_hi  = m_hi;
        e_lo  = m_lo;
        e_dz  = 1'b0;
        e_lat = 33;
        case (o)
            MDU_MULT: begin
                p = 64'(sa * sb);
                e_hi = p[63:32]; e_lo = p[31:0];
            end
            MDU_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                e_hi = p[63:32]; e_lo = p[31:0];
            end
            default: begin
                if (!c_DIV_EN) begin
                    e_dz = 1'b1; e_lat = 0;
                end else if (b == 32'd0) begin
                    e_lo = 32'hFFFF_FFFF; e_hi = a; e_dz = 1'b1;
                end else if (o == MDU_DIV) begin
                    e_lo = 32'(sa / sb); e_hi = 32'(sa % sb);
                end else begin
                    e_lo = a / b; e_hi = a % b;
                end
            end
        endcase
    endtask

    task automatic mt_write(input logic wh, input logic wl, input logic [31:0] v);
        @(negedge clk);
        mthi = wh; mtlo = wl; rs_data = v;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        if (wh) m_hi = v;
        if (wl) m_lo = v;
        check_val("mt_hi", hi, m_hi);
        check_val("mt_lo", lo, m_lo);
    endtask

    // Launch one op; optionally raise mthi/mtlo with start (start must win)
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit pulse_chk, input bit with_mt);
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic        e_dz;
        int          e_lat;
        int          k;
        model(o, a, b, e_hi, e_lo, e_dz, e_lat);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        mthi = with_mt; mtlo = with_mt;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        rs_data = $urandom; rt_data = $urandom;
        check_val("busy_after_start", busy, e_lat != 0);
        k = 0;
        while (!done && k < 100) begin
            if (k == 16) begin
                check_val("hi_hold", hi, m_hi);
                check_val("lo_hold", lo, m_lo);
            end
            @(posedge clk); #1;
            k++;
        end
        check_val("latency", k, e_lat);
        check_val("busy_at_done", busy, 0);
        check_val("hi", hi, e_hi);
        check_val("lo", lo, e_lo);
        check_val("div_zero", div_zero, e_dz);
        m_hi = e_hi;
        m_lo = e_lo;
        if (pulse_chk) begin
            @(posedge clk); #1;
            check_val("done_pulse", done, 0);
            check_val("dz_pulse", div_zero, 0);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  t_op;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic        e_dz;
        int          e_lat;
        int          k;
        int          seen;

        reset = 1'b1; start = 1'b0; op = '0; rs_data = '0; rt_data = '0;
        mthi = 1'b0; mtlo = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_dz", div_zero, 0);
        check_val("rst_hi", hi, 0);
        check_val("rst_lo", lo, 0);
        @(negedge clk);
        reset = 1'b0;

        // Direct HI/LO moves, including both in one cycle
        mt_write(1'b1, 1'b1, 32'h1357_9BDF);
        mt_write(1'b1, 1'b0, 32'hCAFE_0001);
        mt_write(1'b0, 1'b1, 32'h0BAD_F00D);

        // Directed corner operations
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
        run_op(MDU_MULT,  32'hFFFF_FFFD, 32'd7,         1, 0);
        run_op(MDU_MULT,  32'h8000_0000, 32'h8000_0000, 1, 0);
        run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2,         1, 0);
        run_op(MDU_DIVU,  32'd100,       32'd7,         1, 0);
        run_op(MDU_DIVU,  32'h0000_1234, 32'd0,         1, 0);
        run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
        run_op(MDU_DIV,   32'h8000_0005, 32'd0,         1, 0);
        // start wins over mthi/mtlo
        run_op(MDU_MULTU, 32'd5,         32'd6,         1, 1);
        // Back-to-back: next start issued in the done cycle
        run_op(MDU_MULT,  32'h0001_0000, 32'hFFFF_0000, 0, 0);
        run_op(MDU_MULTU, 32'h0000_0009, 32'h0000_0009, 1, 0);

        // start and mthi/mtlo while busy are ignored
        t_op = c_DIV_EN ? MDU_DIVU : MDU_MULTU;
        model(t_op, 32'd100, 32'd7, e_hi, e_lo, e_dz, e_lat);
        @(negedge clk);
        start = 1'b1; op = t_op; rs_data = 32'd100; rt_data = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            start   = (k == 5);
            op      = MDU_MULTU;
            rs_data = (k == 8) ? 32'hAA : 32'd2;
            rt_data = 32'd3;
            mthi    = (k == 8);
            mtlo    = (k == 8);
            @(posedge clk); #1;
            start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            k++;
        end
        check_val("ign_latency", k, 33);
        check_val("ign_hi", hi, e_hi);
        check_val("ign_lo", lo, e_lo);
        m_hi = e_hi;
        m_lo = e_lo;

        // Reset in the middle of a multiply: abort without done
        mt_write(1'b1, 1'b1, 32'h5555_AAAA);
        @(negedge clk);
        start = 1'b1; op = MDU_MULT; rs_data = 32'h1234_5678; rt_data = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_done", done, 0);
        check_val("mid_rst_hi", hi, 0);
        check_val("mid_rst_lo", lo, 0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        check_val("no_done_after_rst", seen, 0);
        run_op(MDU_MULTU, 32'd6, 32'd7, 1, 0);

        // Random operations and moves
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0)
                mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            else
                run_op(2'($urandom_range(0, 3)), pick(), pick(), 1, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mdu_hilo
`default_nettype wire
